// File: rtl/maxpool2d_stream.sv
// ---------------------------------------------------------------------------
// maxpool2d_stream
//
// Channel-serial binary pooling stage. A frame of IC one-bit feature maps is
// captured on the input handshake, then LANES channels per cycle are reduced
// over POOLxPOOL windows (stride POOL) and written into the output maps. When
// every channel group has been written the result is offered on the output
// handshake and held until the consumer takes it.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high; valid/ready are otherwise independent, and the
// data on the valid side is only meaningful while its valid is high.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     img_in/mode hold a frame
//   in_ready     block is idle and can accept a frame
//   mode         00 max (OR), 01 min (AND), 10 majority, 11 behaves as 00
//   img_in       IC input maps, pixel (r,c) at bit r*IMG_IN_SIZE+c
//   out_valid    img_out holds a complete result
//   out_ready    consumer accepts the result
//   img_out      IC pooled maps, pixel (i,j) at bit i*IMG_OUT_SIZE+j
//   dbg_state_o  current FSM state (0 idle, 1 run, 2 done)
// ---------------------------------------------------------------------------
module maxpool2d_stream #(
    parameter int IMG_IN_SIZE  = 28,
    parameter int POOL         = 2,
    parameter int IMG_OUT_SIZE = IMG_IN_SIZE / POOL,
    parameter int IC           = 10,
    parameter int LANES        = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [1:0]                           mode,
    input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   img_in  [0:IC-1],
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out [0:IC-1],
    output logic [1:0]                           dbg_state_o
);

    localparam int IW  = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int OW  = IMG_OUT_SIZE * IMG_OUT_SIZE;
    localparam int WIN = POOL * POOL;
    localparam int PCW = $clog2(WIN + 1);
    localparam int NG  = (IC + LANES - 1) / LANES;
    localparam int GW  = $clog2(NG + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [1:0]      mode_q;
    logic [IW-1:0]   snap_q  [0:IC-1];
    logic [OW-1:0]   out_q   [0:IC-1];
    logic [IW-1:0]   lane_in [0:LANES-1];
    logic [OW-1:0]   lane_out[0:LANES-1];

    // Reduce one whole map. Rows/columns past IMG_OUT_SIZE*POOL are never
    // addressed, so odd trailing pixels drop out naturally.
    function automatic logic [OW-1:0] reduce_map(input logic [IW-1:0] m,
                                                 input logic [1:0]    md);
        logic [OW-1:0]  res;
        logic           any_b;
        logic           all_b;
        logic           b;
        logic [PCW-1:0] cnt;
        res = '0;
        for (int i = 0; i < IMG_OUT_SIZE; i++) begin
            for (int j = 0; j < IMG_OUT_SIZE; j++) begin
                any_b = 1'b0;
                all_b = 1'b1;
                cnt   = '0;
                for (int r = 0; r < POOL; r++) begin
                    for (int c = 0; c < POOL; c++) begin
                        b     = m[(i*POOL + r)*IMG_IN_SIZE + j*POOL + c];
                        any_b = any_b | b;
                        all_b = all_b & b;
                        cnt   = cnt + PCW'(b);
                    end
                end
                case (md)
                    2'b01:   res[i*IMG_OUT_SIZE + j] = all_b;
                    // 2*count >= window size, so a tie counts as a one
                    2'b10:   res[i*IMG_OUT_SIZE + j] = ({cnt, 1'b0} >= (PCW+1)'(WIN));
                    default: res[i*IMG_OUT_SIZE + j] = any_b;
                endcase
            end
        end
        return res;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    grp_d   = '0;
                end
            end
            S_RUN: begin
                // Counter ends at NG after the last group, never beyond.
                grp_d = grp_q + GW'(1);
                if (grp_q == GW'(NG - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign dbg_state_o = state_q;

    // Lane multiplexer: channel ch belongs to group ch/LANES and lane
    // ch%LANES. Iterating over real channels only keeps the tail lanes of
    // the last group inert without any out-of-range index.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = '0;
        end
        for (int ch = 0; ch < IC; ch++) begin
            if (grp_q == GW'(ch / LANES)) begin
                lane_in[ch % LANES] = snap_q[ch];
            end
        end
        for (int l = 0; l < LANES; l++) begin
            lane_out[l] = reduce_map(lane_in[l], mode_q);
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'b00;
            for (int ch = 0; ch < IC; ch++) begin
                snap_q[ch] <= '0;
                out_q[ch]  <= '0;
            end
        end else begin
            if (state_q == S_IDLE && in_valid) begin
                mode_q <= mode;
                for (int ch = 0; ch < IC; ch++) begin
                    snap_q[ch] <= img_in[ch];
                    out_q[ch]  <= '0;
                end
            end else if (state_q == S_RUN) begin
                for (int ch = 0; ch < IC; ch++) begin
                    if (grp_q == GW'(ch / LANES)) begin
                        out_q[ch] <= lane_out[ch % LANES];
                    end
                end
            end
        end
    end

    assign img_out = out_q;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// ---------------------------------------------------------------------------
// tb_maxpool2d_stream
//
// Two instances: A (4x4 maps, POOL 2, IC 3, LANES 2, two groups) and
// B (5x5 maps, POOL 2, IC 4, LANES 4, one group, odd trailing row/column).
// Each scenario task drives a frame and checks the outputs against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_maxpool2d_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // ---------------- instance A ----------------
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_mode, a_state;
    logic [15:0] a_img_in  [0:2];
    logic [3:0]  a_img_out [0:2];

    maxpool2d_stream #(
        .IMG_IN_SIZE(4), .POOL(2), .IC(3), .LANES(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
        .img_in(a_img_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .img_out(a_img_out), .dbg_state_o(a_state)
    );

    // ---------------- instance B ----------------
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]  b_mode, b_state;
    logic [24:0] b_img_in  [0:3];
    logic [3:0]  b_img_out [0:3];

    maxpool2d_stream #(
        .IMG_IN_SIZE(5), .POOL(2), .IC(4), .LANES(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
        .img_in(b_img_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .img_out(b_img_out), .dbg_state_o(b_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Present a frame, take it on the next edge, then scramble the inputs
    // so late changes to img_in/mode would show up in the result.
    task automatic a_send(input logic [15:0] m0, input logic [15:0] m1,
                          input logic [15:0] m2, input logic [1:0] md);
        @(negedge clk);
        a_img_in[0] = m0;
        a_img_in[1] = m1;
        a_img_in[2] = m2;
        a_mode      = md;
        a_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
        a_img_in[0] = 16'($urandom_range(0, 65535));
        a_img_in[1] = 16'($urandom_range(0, 65535));
        a_img_in[2] = 16'($urandom_range(0, 65535));
        a_mode      = ~md;
    endtask

    task automatic b_send(input logic [24:0] m0, input logic [24:0] m1,
                          input logic [24:0] m2, input logic [24:0] m3);
        @(negedge clk);
        b_img_in[0] = m0;
        b_img_in[1] = m1;
        b_img_in[2] = m2;
        b_img_in[3] = m3;
        b_mode      = 2'b00;
        b_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid  = 1'b0;
        for (int i = 0; i < 4; i++) b_img_in[i] = 25'($urandom);
        b_mode      = 2'b01;
    endtask

    // Count negedges after the accept edge until out_valid; -1 on timeout.
    task automatic a_wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (a_out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic b_wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b_out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic a_release();
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
    endtask

    task automatic b_release();
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_mode = 2'b00;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_mode = 2'b00;
        for (int i = 0; i < 3; i++) a_img_in[i] = '0;
        for (int i = 0; i < 4; i++) b_img_in[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_a_ctrl: in_ready=%b out_valid=%b state=%0d, want 1 0 0",
                     a_in_ready, a_out_valid, a_state);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_img_out[i] !== 4'h0) begin
                errors++;
                $display("FAIL reset_a_out%0d: got %h want 0", i, a_img_out[i]);
            end
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_b_ctrl: in_ready=%b out_valid=%b, want 1 0",
                     b_in_ready, b_out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max();
        int lat;
        a_send(16'h0001, 16'hFFFF, 16'h0000, 2'b00);
        a_wait_valid(lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL max_latency: got %0d want 3", lat);
        end
        checks++;
        if (a_img_out[0] !== 4'h1 || a_img_out[1] !== 4'hF || a_img_out[2] !== 4'h0) begin
            errors++;
            $display("FAIL max_out: got %h %h %h want 1 f 0",
                     a_img_out[0], a_img_out[1], a_img_out[2]);
        end
        a_release();
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL max_release: in_ready=%b out_valid=%b want 1 0",
                     a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_min();
        int lat;
        a_send(16'h0001, 16'hFFFF, 16'h0000, 2'b01);
        a_wait_valid(lat);
        checks++;
        if (lat !== 3 || a_img_out[0] !== 4'h0 || a_img_out[1] !== 4'hF ||
            a_img_out[2] !== 4'h0) begin
            errors++;
            $display("FAIL min_out: lat=%0d got %h %h %h want lat 3 0 f 0",
                     lat, a_img_out[0], a_img_out[1], a_img_out[2]);
        end
        a_release();
    endtask

    task automatic test_majority();
        int lat;
        a_send(16'h0015, 16'h4C00, 16'hFFFF, 2'b10);
        a_wait_valid(lat);
        checks++;
        if (lat !== 3 || a_img_out[0] !== 4'h1 || a_img_out[1] !== 4'h8 ||
            a_img_out[2] !== 4'hF) begin
            errors++;
            $display("FAIL maj_out: lat=%0d got %h %h %h want lat 3 1 8 f",
                     lat, a_img_out[0], a_img_out[1], a_img_out[2]);
        end
        a_release();
    endtask

    task automatic test_reserved_mode();
        int lat;
        a_send(16'h0001, 16'hFFFF, 16'h8000, 2'b11);
        a_wait_valid(lat);
        checks++;
        if (lat !== 3 || a_img_out[0] !== 4'h1 || a_img_out[1] !== 4'hF ||
            a_img_out[2] !== 4'h8) begin
            errors++;
            $display("FAIL mode11_out: lat=%0d got %h %h %h want lat 3 1 f 8",
                     lat, a_img_out[0], a_img_out[1], a_img_out[2]);
        end
        a_release();
    endtask

    task automatic test_backpressure();
        int lat;
        a_send(16'h0001, 16'hFFFF, 16'h0000, 2'b00);
        a_wait_valid(lat);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 4) begin
                a_img_in[0] = 16'hFFFF;
                a_img_in[1] = 16'h0000;
                a_img_in[2] = 16'hFFFF;
                a_mode      = 2'b00;
                a_in_valid  = 1'b1;
            end else begin
                a_in_valid  = 1'b0;
            end
            checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_img_out[0] !== 4'h1 ||
                a_img_out[1] !== 4'hF || a_img_out[2] !== 4'h0) begin
                errors++;
                $display("FAIL hold_%0d: ov=%b ir=%b out=%h %h %h want 1 0 1 f 0",
                         k, a_out_valid, a_in_ready,
                         a_img_out[0], a_img_out[1], a_img_out[2]);
            end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_img_out[1] !== 4'hF) begin
            errors++;
            $display("FAIL hold_release: ir=%b ov=%b out1=%h want 1 0 f",
                     a_in_ready, a_out_valid, a_img_out[1]);
        end
    endtask

    // in_valid and out_ready held high: accepts must be NG+2 = 4 cycles apart.
    task automatic test_back_to_back();
        int acc_cyc[$];
        @(negedge clk);
        a_img_in[0] = 16'h0001;
        a_img_in[1] = 16'hFFFF;
        a_img_in[2] = 16'h0000;
        a_mode      = 2'b00;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (a_in_ready === 1'b1) acc_cyc.push_back(cyc);
            if (a_out_valid === 1'b1) begin
                checks++;
                if (a_in_ready !== 1'b0 || a_img_out[0] !== 4'h1 ||
                    a_img_out[1] !== 4'hF || a_img_out[2] !== 4'h0) begin
                    errors++;
                    $display("FAIL b2b_done_%0d: ir=%b out=%h %h %h want 0 1 f 0",
                             cyc, a_in_ready, a_img_out[0], a_img_out[1], a_img_out[2]);
                end
            end
        end
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        checks++;
        if (acc_cyc.size() != 4) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d want 4", acc_cyc.size());
        end else if (acc_cyc[1] - acc_cyc[0] != 4 || acc_cyc[3] - acc_cyc[2] != 4) begin
            errors++;
            $display("FAIL b2b_period: got %0d %0d want 4 4",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[3] - acc_cyc[2]);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        a_send(16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00);
        @(posedge clk);
        #3;
        checks++;
        if (a_img_out[0] !== 4'hF || a_state !== 2'd1) begin
            errors++;
            $display("FAIL arst_pre: out0=%h state=%0d want f 1", a_img_out[0], a_state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_img_out[0] !== 4'h0 ||
            a_img_out[1] !== 4'h0 || a_img_out[2] !== 4'h0) begin
            errors++;
            $display("FAIL arst_now: ir=%b ov=%b out=%h %h %h want 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_img_out[0], a_img_out[1], a_img_out[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_send(16'h0001, 16'hFFFF, 16'h0000, 2'b01);
        a_wait_valid(lat);
        checks++;
        if (lat !== 3 || a_img_out[0] !== 4'h0 || a_img_out[1] !== 4'hF ||
            a_img_out[2] !== 4'h0) begin
            errors++;
            $display("FAIL arst_after: lat=%0d got %h %h %h want lat 3 0 f 0",
                     lat, a_img_out[0], a_img_out[1], a_img_out[2]);
        end
        a_release();
    endtask

    task automatic test_odd_size();
        int lat;
        b_send(25'h1F84210, 25'h1F84210, 25'h1F84210, 25'h1F84210);
        b_wait_valid(lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL odd_latency: got %0d want 2", lat);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_img_out[i] !== 4'h0) begin
                errors++;
                $display("FAIL odd_edge_out%0d: got %h want 0", i, b_img_out[i]);
            end
        end
        b_release();
        b_send(25'h0040000, 25'h0000002, 25'h1FFFFFF, 25'h0000400);
        b_wait_valid(lat);
        checks++;
        if (lat !== 2 || b_img_out[0] !== 4'h8 || b_img_out[1] !== 4'h1 ||
            b_img_out[2] !== 4'hF || b_img_out[3] !== 4'h4) begin
            errors++;
            $display("FAIL odd_pix: lat=%0d got %h %h %h %h want lat 2 8 1 f 4",
                     lat, b_img_out[0], b_img_out[1], b_img_out[2], b_img_out[3]);
        end
        b_release();
    endtask

    initial begin
        test_reset();
        test_max();
        test_min();
        test_majority();
        test_reserved_mode();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_odd_size();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
